lcd_ctrl: RTL and testbench
===========================

# lcd_ctrl

Sequencer between the 32-bit LCD PIO export of the PCIe core and the HD44780-compatible character LCD pins on the board. Software writes a command word to the PIO; this block detects each new request, generates the RS/E/data bus timing and enforces the controller's execution delays, so the driver never bit-bangs the bus. After reset it optionally runs the power-up init sequence on its own. Status outputs are wired back into a PIO input so the driver can poll them.

## Interface
- `T_PWR`, default 750000: power-up wait in cycles, 15 ms at 50 MHz.
- `T_SETUP`, default 4: cycles RS/data are stable before E rises.
- `T_EN`, default 12: E high width in cycles.
- `T_HOLD`, default 4: cycles after E falls before the wait phase.
- `T_CMD`, default 2000: execution wait for ordinary writes, 40 µs.
- `T_CLR`, default 82000: execution wait for clear/home, 1.64 ms.
- `clk` input, 1 bit: 50 MHz system clock.
- `reset_n` input, 1 bit: synchronous reset, active low.
- `cmd_word` input, 32 bits: PIO word.
  - [7:0] data.
  - [8] RS.
  - [9] request toggle.
  - [10] display power.
  - [11] backlight.
  - [12] overflow clear toggle.
  - [31:13] ignored.
- `lcd_data` output, 8 bits: LCD DB7..DB0.
- `lcd_rs` output, 1 bit: register select.
- `lcd_rw` output, 1 bit: constant 0 (write only).
- `lcd_en` output, 1 bit: enable strobe.
- `lcd_on` output, 1 bit: display power.
- `lcd_blon` output, 1 bit: backlight.
- `busy` output, 1 bit: an init or write is in progress, or a write is pending.
- `overflow` output, 1 bit: sticky flag, a request was dropped.

## Operation
- Reset value of every output is 0. State after reset is PWR_WAIT (macro defined) or IDLE (macro undefined).
- Request detection:
  - `cmd_word[9]` is registered each cycle.
  - A difference between the current and registered value is one request and captures {RS, data}.
  - The registered toggle resets to 0. A toggle value of 1 at reset release is therefore a request.
- `lcd_on` and `lcd_blon` are registered copies of bits 10 and 11. Latency is 1 cycle, independent of the FSM.
- Pending buffer:
  - One deep.
  - A request arriving while the FSM is not IDLE is stored as pending.
  - A request arriving while pending is already full is dropped and sets `overflow`.
  - A change on bit 12 clears `overflow`. If a drop and a clear happen in the same cycle, the drop wins.
  - Requests arriving during init are buffered under the same rules.
- FSM states:
  - PWR_WAIT: wait T_PWR cycles, then go to INIT.
  - INIT: load init ROM entry k (0x38, 0x0C, 0x01, 0x06, RS=0), go to SETUP. After entry 3 completes, go to IDLE.
  - IDLE: on a request or pending entry, load the bus and go to SETUP. A pending entry is taken before a same-cycle new request; the new request then becomes pending.
  - SETUP: wait T_SETUP cycles, then go to PULSE.
  - PULSE: `lcd_en`=1 for T_EN cycles, then go to HOLD.
  - HOLD: wait T_HOLD cycles, then go to WAIT.
  - WAIT: wait T_CLR if RS=0 and data ∈ {0x01, 0x02, 0x03}, else T_CMD. Then go to INIT (init active) or IDLE.
- `lcd_data` and `lcd_rs` are held from SETUP entry until the next load.
- `busy` = (state ≠ IDLE) | pending valid.
- Reset mid-operation:
  - `lcd_en` drops in the same cycle.
  - The pending entry and `overflow` clear.
  - Init restarts from PWR_WAIT.

## Timing
- Request toggle to `lcd_en` rising, IDLE, no pending: 2 + T_SETUP cycles (1 cycle edge detect, 1 cycle load).
- Full write occupancy: 1 + T_SETUP + T_EN + T_HOLD + wait cycles until back in IDLE.
- Back-to-back: the pending request is loaded in the first IDLE cycle; no idle gap beyond that 1 cycle.
- Timer:
  - 20-bit down counter, loaded with N−1 on state entry.
  - The state exits when the counter is 0, so every phase lasts exactly N cycles.
  - Every parameter must be ≥1 and < 2^20.

## Configuration
- `LCD_CTRL_INIT_EN` defined:
  - PWR_WAIT and INIT are present.
  - `busy`=1 from the first cycle after reset release until the 4th init write's WAIT completes.
- Undefined:
  - Init ROM and PWR_WAIT are removed; reset goes directly to IDLE with `busy`=0.
  - Software is responsible for the init sequence.

## Structure
- `lcd_ctrl_pkg`:
  - State enum.
  - Init ROM constant array (4 × 8 bits) and init count.
  - Clear/home opcode constants.
  - Command-word bit index constants.
- Sub-module `lcd_ctrl_timer`: loadable 20-bit down counter with `load`, `value`, `done`.

## Test plan
All scenarios use small parameters: T_PWR=20, T_SETUP=2, T_EN=3, T_HOLD=2, T_CMD=10, T_CLR=30.
- Init (macro on): release reset → writes 0x38, 0x0C, 0x01, 0x06 with RS=0. E high exactly 3 cycles each. Wait after 0x01 is 30 cycles, others 10. `busy` falls afterwards.
- Single write: toggle bit 9 with data 0x41, RS=1 → `lcd_en` rises 4 cycles later with `lcd_data`=0x41, `lcd_rs`=1. `busy` is high for 18 cycles.
- Back-to-back: two toggles 3 cycles apart → second write starts 1 cycle after the first returns to IDLE. `overflow` stays 0.
- Overflow: three toggles during one write → third is dropped and `overflow`=1. Toggling bit 12 → `overflow`=0.
- Reset mid-PULSE: `reset_n`=0 while E=1 → E=0 the next edge. Pending and `overflow` clear. Init restarts.
- Macro off: after reset `busy`=0. A 0x01 write with RS=0 → WAIT lasts 30 cycles.

Source files
------------

// File: rtl/lcd_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// lcd_ctrl_pkg
// Shared definitions for the HD44780 character LCD sequencer:
//   - FSM state enum
//   - power-up init ROM (4 x 8 bit, all written with RS=0) and entry count
//   - clear/home opcodes, which need the long execution wait
//   - bit positions inside the 32-bit PIO command word
//   - phase timer width and a helper that picks the long-wait opcodes
// ---------------------------------------------------------------------------
package lcd_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PWR_WAIT = 3'd1,
        ST_INIT     = 3'd2,
        ST_SETUP    = 3'd3,
        ST_PULSE    = 3'd4,
        ST_HOLD     = 3'd5,
        ST_WAIT     = 3'd6
    } state_t;

    localparam int TIMER_W    = 20;
    localparam int INIT_COUNT = 4;

    // Entry 0 is the least significant byte: 0x38, 0x0C, 0x01, 0x06.
    localparam logic [INIT_COUNT-1:0][7:0] INIT_ROM = {8'h06, 8'h01, 8'h0C, 8'h38};

    localparam logic [7:0] OP_CLEAR    = 8'h01;
    localparam logic [7:0] OP_HOME     = 8'h02;
    localparam logic [7:0] OP_HOME_ALT = 8'h03;

    localparam int BIT_DATA_MSB = 7;
    localparam int BIT_RS       = 8;
    localparam int BIT_REQ      = 9;
    localparam int BIT_PWR      = 10;
    localparam int BIT_BL       = 11;
    localparam int BIT_OVF_CLR  = 12;

    // Clear display and return home execute far slower than every other
    // instruction, so they get the long wait.
    function automatic logic isSlowCmd(input logic rs, input logic [7:0] data);
        return !rs && ((data == OP_CLEAR) || (data == OP_HOME) || (data == OP_HOME_ALT));
    endfunction

endpackage

// File: rtl/lcd_ctrl_if.sv
// ---------------------------------------------------------------------------
// lcd_ctrl_if
// Bundle between the PCIe core's LCD PIO and the LCD pins.
//   cmd_word  : 32-bit PIO command word (software -> sequencer)
//   lcd_data  : DB7..DB0
//   lcd_rs    : register select
//   lcd_rw    : read/write, always write
//   lcd_en    : enable strobe
//   lcd_on    : display power
//   lcd_blon  : backlight
//   busy      : init or write in progress, or a write is waiting
//   overflow  : sticky, a request was dropped
// master = PIO side (drives cmd_word), slave = sequencer.
// ---------------------------------------------------------------------------
interface lcd_ctrl_if;

    logic [31:0] cmd_word;
    logic [7:0]  lcd_data;
    logic        lcd_rs;
    logic        lcd_rw;
    logic        lcd_en;
    logic        lcd_on;
    logic        lcd_blon;
    logic        busy;
    logic        overflow;

    modport master (
        output cmd_word,
        input  lcd_data, lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon, busy, overflow
    );

    modport slave (
        input  cmd_word,
        output lcd_data, lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon, busy, overflow
    );

endinterface

// File: rtl/lcd_ctrl_timer.sv
// ---------------------------------------------------------------------------
// lcd_ctrl_timer
// Loadable 20-bit down counter timing every sequencer phase.
//   clk         : system clock
//   i_load      : load i_loadValue this cycle (phase entry or reset)
//   i_loadValue : phase length minus one
//   o_value     : current count
//   o_done      : count has reached zero, the phase ends on this edge
// No reset of its own: the parent holds i_load high while in reset.
// ---------------------------------------------------------------------------
module lcd_ctrl_timer
    import lcd_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               i_load,
    input  logic [TIMER_W-1:0] i_loadValue,
    output logic [TIMER_W-1:0] o_value,
    output logic               o_done
);

    logic [TIMER_W-1:0] r_count;

    // Loading N-1 on entry and leaving when the count is zero makes a
    // phase last exactly N cycles; the counter parks at zero afterwards.
    always_ff @(posedge clk) begin
        if (i_load) begin
            r_count <= i_loadValue;
        end else if (r_count != '0) begin
            r_count <= r_count - TIMER_W'(1);
        end
    end

    assign o_value = r_count;
    assign o_done  = (r_count == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// ---------------------------------------------------------------------------
// lcd_ctrl
// Sequencer between the LCD PIO word and an HD44780 character LCD.
// Software flips cmd_word[9] to request a write of {RS, data}; this block
// generates the RS/E/data timing and the execution waits.
//   clk      : 50 MHz system clock
//   reset_n  : synchronous reset, active low
//   bus      : lcd_ctrl_if.slave (cmd_word in, LCD pins and status out)
// Parameters (cycles, each 1 .. 2^20-1): T_PWR, T_SETUP, T_EN, T_HOLD,
// T_CMD, T_CLR.
// Optional feature: define LCD_CTRL_INIT_EN to run the power-up wait and
// the 4-entry init sequence by hardware after reset; without it reset
// lands in IDLE and software does the init.
// ---------------------------------------------------------------------------
module lcd_ctrl
    import lcd_ctrl_pkg::*;
#(
    parameter int unsigned T_PWR   = 750000,
    parameter int unsigned T_SETUP = 4,
    parameter int unsigned T_EN    = 12,
    parameter int unsigned T_HOLD  = 4,
    parameter int unsigned T_CMD   = 2000,
    parameter int unsigned T_CLR   = 82000
)(
    input logic       clk,
    input logic       reset_n,
    lcd_ctrl_if.slave bus
);

`ifdef LCD_CTRL_INIT_EN
    localparam state_t RESET_STATE = ST_PWR_WAIT;
`else
    localparam state_t RESET_STATE = ST_IDLE;
`endif

    state_t             r_state;
    state_t             w_nextState;

    logic               r_reqToggle;
    logic               r_clrToggle;
    logic               r_reqValid;
    logic               r_reqRs;
    logic [7:0]         r_reqData;
    logic               r_pendValid;
    logic               r_pendRs;
    logic [7:0]         r_pendData;
    logic               r_overflow;
    logic               r_lcdOn;
    logic               r_lcdBlon;
    logic               r_lcdRs;
    logic [7:0]         r_lcdData;

    logic               w_reqEdge;
    logic               w_clrEdge;
    logic               w_idle;
    logic               w_takePend;
    logic               w_takeReq;
    logic               w_storeReq;
    logic               w_dropReq;
    logic               w_started;

    logic               w_timerLoad;
    logic [TIMER_W-1:0] w_timerLoadValue;
    logic [TIMER_W-1:0] w_unusedTimerValue;
    logic               w_timerDone;
    logic               w_unusedCmdBits;

`ifdef LCD_CTRL_INIT_EN
    logic [1:0]         r_initIdx;
    logic               r_initActive;
    logic               r_started;
    logic               w_loadInit;
    logic               w_initStep;
    logic               w_initDone;
`endif

    assign w_reqEdge       = bus.cmd_word[BIT_REQ] ^ r_reqToggle;
    assign w_clrEdge       = bus.cmd_word[BIT_OVF_CLR] ^ r_clrToggle;
    assign w_unusedCmdBits = ^bus.cmd_word[31:13];

    // Edge detection on the request and overflow-clear toggles. The toggle
    // registers reset to 0, so a toggle already at 1 when reset releases is
    // seen as a request. The detected request is held for one cycle in
    // r_reqValid together with its {RS, data}. Power and backlight are plain
    // one-cycle copies that do not depend on the FSM.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_reqToggle <= 1'b0;
            r_clrToggle <= 1'b0;
            r_reqValid  <= 1'b0;
            r_reqRs     <= 1'b0;
            r_reqData   <= 8'h00;
            r_lcdOn     <= 1'b0;
            r_lcdBlon   <= 1'b0;
        end else begin
            r_reqToggle <= bus.cmd_word[BIT_REQ];
            r_clrToggle <= bus.cmd_word[BIT_OVF_CLR];
            r_reqValid  <= w_reqEdge;
            if (w_reqEdge) begin
                r_reqRs   <= bus.cmd_word[BIT_RS];
                r_reqData <= bus.cmd_word[BIT_DATA_MSB:0];
            end
            r_lcdOn     <= bus.cmd_word[BIT_PWR];
            r_lcdBlon   <= bus.cmd_word[BIT_BL];
        end
    end

    // In IDLE the pending entry goes first; a request arriving in that same
    // cycle drops into the slot just vacated. Outside IDLE a request fills
    // an empty slot or, if the slot is full, is lost and flags overflow.
    assign w_idle     = (r_state == ST_IDLE);
    assign w_takePend = w_idle && r_pendValid;
    assign w_takeReq  = w_idle && !r_pendValid && r_reqValid;
    assign w_storeReq = r_reqValid && ((!w_idle && !r_pendValid) || w_takePend);
    assign w_dropReq  = r_reqValid && !w_idle && r_pendValid;

    // One-deep pending buffer and the sticky overflow flag. A drop beats a
    // clear arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pendValid <= 1'b0;
            r_pendRs    <= 1'b0;
            r_pendData  <= 8'h00;
            r_overflow  <= 1'b0;
        end else begin
            if (w_storeReq) begin
                r_pendValid <= 1'b1;
                r_pendRs    <= r_reqRs;
                r_pendData  <= r_reqData;
            end else if (w_takePend) begin
                r_pendValid <= 1'b0;
            end
            if (w_dropReq) begin
                r_overflow <= 1'b1;
            end else if (w_clrEdge) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // RS and data are driven from the moment a write leaves for SETUP and
    // stay put until the next write is loaded.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_lcdRs   <= 1'b0;
            r_lcdData <= 8'h00;
        end else if (w_takePend) begin
            r_lcdRs   <= r_pendRs;
            r_lcdData <= r_pendData;
        end else if (w_takeReq) begin
            r_lcdRs   <= r_reqRs;
            r_lcdData <= r_reqData;
        end
`ifdef LCD_CTRL_INIT_EN
        else if (w_loadInit) begin
            r_lcdRs   <= 1'b0;
            r_lcdData <= INIT_ROM[r_initIdx];
        end
`endif
    end

`ifdef LCD_CTRL_INIT_EN
    // Init bookkeeping: which ROM entry is next, whether the hardware init
    // still owns the bus, and a flag that keeps busy low while in reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_initIdx    <= 2'd0;
            r_initActive <= 1'b1;
            r_started    <= 1'b0;
        end else begin
            r_started <= 1'b1;
            if (w_initStep) begin
                r_initIdx <= r_initIdx + 2'd1;
            end
            if (w_initDone) begin
                r_initActive <= 1'b0;
            end
        end
    end
    assign w_started = r_started;
`else
    assign w_started = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= RESET_STATE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. Every timed phase leaves when the timer reads zero;
    // WAIT returns to INIT while the init sequence still has entries left.
    always_comb begin
        w_nextState = r_state;
`ifdef LCD_CTRL_INIT_EN
        w_loadInit  = 1'b0;
        w_initStep  = 1'b0;
        w_initDone  = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (r_pendValid || r_reqValid) begin
                    w_nextState = ST_SETUP;
                end
            end
`ifdef LCD_CTRL_INIT_EN
            ST_PWR_WAIT: begin
                if (w_timerDone) begin
                    w_nextState = ST_INIT;
                end
            end
            ST_INIT: begin
                w_loadInit  = 1'b1;
                w_nextState = ST_SETUP;
            end
`endif
            ST_SETUP: begin
                if (w_timerDone) begin
                    w_nextState = ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (w_timerDone) begin
                    w_nextState = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_timerDone) begin
                    w_nextState = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_timerDone) begin
`ifdef LCD_CTRL_INIT_EN
                    if (r_initActive && (r_initIdx != 2'(INIT_COUNT - 1))) begin
                        w_initStep  = 1'b1;
                        w_nextState = ST_INIT;
                    end else begin
                        w_initDone  = r_initActive;
                        w_nextState = ST_IDLE;
                    end
`else
                    w_nextState = ST_IDLE;
`endif
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // The timer reloads on every state change and throughout reset, which
    // preloads the power-up wait. The WAIT length depends on the byte
    // already on the bus, loaded when the write entered SETUP.
    assign w_timerLoad = !reset_n || (w_nextState != r_state);

    always_comb begin
        w_timerLoadValue = TIMER_W'(T_PWR - 1);
        if (reset_n) begin
            case (w_nextState)
                ST_SETUP: w_timerLoadValue = TIMER_W'(T_SETUP - 1);
                ST_PULSE: w_timerLoadValue = TIMER_W'(T_EN - 1);
                ST_HOLD:  w_timerLoadValue = TIMER_W'(T_HOLD - 1);
                ST_WAIT:  w_timerLoadValue = isSlowCmd(r_lcdRs, r_lcdData) ?
                                             TIMER_W'(T_CLR - 1) : TIMER_W'(T_CMD - 1);
                default:  w_timerLoadValue = TIMER_W'(T_PWR - 1);
            endcase
        end
    end

    lcd_ctrl_timer u_timer (
        .clk         (clk),
        .i_load      (w_timerLoad),
        .i_loadValue (w_timerLoadValue),
        .o_value     (w_unusedTimerValue),
        .o_done      (w_timerDone)
    );

    // Busy also covers the one cycle a freshly detected request spends
    // before it is loaded, so software never sees a gap after a toggle.
    assign bus.busy     = w_started && (!w_idle || r_pendValid || r_reqValid);
    assign bus.lcd_en   = (r_state == ST_PULSE);
    assign bus.lcd_rw   = 1'b0;
    assign bus.lcd_rs   = r_lcdRs;
    assign bus.lcd_data = r_lcdData;
    assign bus.lcd_on   = r_lcdOn;
    assign bus.lcd_blon = r_lcdBlon;
    assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_lcd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lcd_ctrl
// Directed bench for lcd_ctrl with small timing parameters. Follows
// LCD_CTRL_INIT_EN the same way the design does.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lcd_ctrl;

    localparam int TP  = 20;
    localparam int TS  = 2;
    localparam int TE  = 3;
    localparam int TH  = 2;
    localparam int TC  = 10;
    localparam int TCL = 30;

    // Offset between consecutive back-to-back write loads: SETUP..WAIT plus
    // the single IDLE cycle in which the pending entry is taken.
    localparam int SPAN = TS + TE + TH + TC + 1;

    typedef struct {
        logic [31:0] word;
        logic        expOn;
        logic        expBlon;
        logic        expBusy;
        logic        expOvf;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    int   total = 0;
    int   bad = 0;
    logic curToggle = 1'b0;
    logic curClr = 1'b0;
    logic curOn = 1'b0;
    logic curBl = 1'b0;
    vec_t vecs[6];

    lcd_ctrl_if bus();

    lcd_ctrl #(
        .T_PWR   (TP),
        .T_SETUP (TS),
        .T_EN    (TE),
        .T_HOLD  (TH),
        .T_CMD   (TC),
        .T_CLR   (TCL)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Free-running 100 MHz bench clock.
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] word);
        bus.cmd_word = word;
    endtask

    function automatic logic [31:0] mkWord(input logic rs, input logic [7:0] data);
        return {19'd0, curClr, curBl, curOn, curToggle, rs, data};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    task automatic sendWrite(input logic rs, input logic [7:0] data);
        curToggle = ~curToggle;
        applyStimulus(mkWord(rs, data));
    endtask

    function automatic logic [7:0] expInit(input int i);
        case (i)
            0:       return 8'h38;
            1:       return 8'h0C;
            2:       return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    // Request applied in the current cycle (k=0); checks the E window,
    // busy span and the bus contents while E is high.
    task automatic checkWrite(input string tag, input logic rs, input logic [7:0] data, input int waitCycles);
        int busyEnd = 1 + TS + TE + TH + waitCycles;
        for (int k = 1; k <= busyEnd + 2; k++) begin
            logic expEn;
            tick();
            expEn = (k >= 2 + TS) && (k <= 1 + TS + TE);
            checkOutput({tag, " en"}, 32'(bus.lcd_en), 32'(expEn));
            checkOutput({tag, " busy"}, 32'(bus.busy), 32'(k <= busyEnd));
            if (expEn) begin
                checkOutput({tag, " data"}, 32'(bus.lcd_data), 32'(data));
                checkOutput({tag, " rs"}, 32'(bus.lcd_rs), 32'(rs));
            end
        end
    endtask

    // Reset released in the current cycle; follows the four init writes.
    task automatic checkInitSequence(input string tag);
        int   idx = 0;
        int   width = 0;
        int   lastHigh = 0;
        int   k = 0;
        int   prevWait;
        logic prevEn = 1'b0;
        logic done = 1'b0;
        while (!done && k < 400) begin
            tick();
            k++;
            if (k == 1) checkOutput({tag, " busy start"}, 32'(bus.busy), 32'd1);
            if (bus.lcd_en && !prevEn) begin
                if (idx == 0) begin
                    checkOutput({tag, " first en"}, 32'(k), 32'(TP + 1 + TS));
                end else begin
                    prevWait = (expInit(idx - 1) == 8'h01) ? TCL : TC;
                    checkOutput({tag, " gap"}, 32'(k - lastHigh), 32'(TH + prevWait + 1 + TS + 1));
                end
                checkOutput({tag, " data"}, 32'(bus.lcd_data), 32'(expInit(idx)));
                checkOutput({tag, " rs"}, 32'(bus.lcd_rs), 32'd0);
                idx++;
                width = 0;
            end
            if (bus.lcd_en) begin
                width++;
                lastHigh = k;
            end
            if (!bus.lcd_en && prevEn) checkOutput({tag, " width"}, 32'(width), 32'(TE));
            if (idx == 4 && !bus.lcd_en && !bus.busy) begin
                checkOutput({tag, " busy end"}, 32'(k), 32'(lastHigh + TH + TC + 1));
                done = 1'b1;
            end
            prevEn = bus.lcd_en;
        end
        checkOutput({tag, " finished"}, 32'(done), 32'd1);
    endtask

    // Hard stop in case something never settles.
    initial begin
        #300000;
        bad++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int rises;
        logic prevEn;

        vecs[0] = '{32'h0000_0400, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'h0000_0800, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{32'h0000_0C00, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{32'hFFFF_E0FF, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{32'hFFFF_ECFF, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0};

        $display("[TB] reset");
        reset_n = 1'b0;
        applyStimulus(32'h0000_0C00);
        tick();
        tick();
        tick();
        checkOutput("reset en", 32'(bus.lcd_en), 32'd0);
        checkOutput("reset data", 32'(bus.lcd_data), 32'd0);
        checkOutput("reset rs", 32'(bus.lcd_rs), 32'd0);
        checkOutput("reset rw", 32'(bus.lcd_rw), 32'd0);
        checkOutput("reset on", 32'(bus.lcd_on), 32'd0);
        checkOutput("reset blon", 32'(bus.lcd_blon), 32'd0);
        checkOutput("reset busy", 32'(bus.busy), 32'd0);
        checkOutput("reset ovf", 32'(bus.overflow), 32'd0);
        applyStimulus(mkWord(1'b0, 8'h00));
        reset_n = 1'b1;

`ifdef LCD_CTRL_INIT_EN
        $display("[TB] power-up init");
        checkInitSequence("init");
`else
        $display("[TB] idle after reset");
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput("idle busy", 32'(bus.busy), 32'd0);
            checkOutput("idle en", 32'(bus.lcd_en), 32'd0);
        end
`endif

        $display("[TB] power/backlight vectors");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].word);
            tick();
            checkOutput($sformatf("vec%0d on", i), 32'(bus.lcd_on), 32'(vecs[i].expOn));
            checkOutput($sformatf("vec%0d blon", i), 32'(bus.lcd_blon), 32'(vecs[i].expBlon));
            checkOutput($sformatf("vec%0d busy", i), 32'(bus.busy), 32'(vecs[i].expBusy));
            checkOutput($sformatf("vec%0d ovf", i), 32'(bus.overflow), 32'(vecs[i].expOvf));
        end
        curOn = 1'b0;
        curBl = 1'b0;

        $display("[TB] single write");
        sendWrite(1'b1, 8'h41);
        checkWrite("write41", 1'b1, 8'h41, TC);

        $display("[TB] clear display write");
        sendWrite(1'b0, 8'h01);
        checkWrite("clear", 1'b0, 8'h01, TCL);

        $display("[TB] back-to-back writes");
        sendWrite(1'b1, 8'h48);
        for (int k = 1; k <= 2 * SPAN + 4; k++) begin
            logic e1;
            logic e2;
            tick();
            if (k == 3) sendWrite(1'b1, 8'h49);
            e1 = (k >= 2 + TS) && (k <= 1 + TS + TE);
            e2 = (k >= 2 + TS + SPAN) && (k <= 1 + TS + TE + SPAN);
            checkOutput("b2b en", 32'(bus.lcd_en), 32'(e1 || e2));
            checkOutput("b2b busy", 32'(bus.busy), 32'(k <= 2 * SPAN));
            checkOutput("b2b ovf", 32'(bus.overflow), 32'd0);
            if (e1) checkOutput("b2b data1", 32'(bus.lcd_data), 32'h48);
            if (e2) checkOutput("b2b data2", 32'(bus.lcd_data), 32'h49);
        end

        $display("[TB] overflow");
        rises = 0;
        prevEn = 1'b0;
        sendWrite(1'b1, 8'h61);
        for (int k = 1; k <= 2 * SPAN + 6; k++) begin
            tick();
            if (k == 2) sendWrite(1'b1, 8'h62);
            if (k == 4) sendWrite(1'b1, 8'h63);
            checkOutput("ovf flag", 32'(bus.overflow), 32'(k >= 6));
            if (bus.lcd_en && !prevEn) begin
                rises++;
                checkOutput("ovf data", 32'(bus.lcd_data), (rises == 1) ? 32'h61 : 32'h62);
            end
            prevEn = bus.lcd_en;
        end
        checkOutput("ovf writes", 32'(rises), 32'd2);
        checkOutput("ovf busy end", 32'(bus.busy), 32'd0);
        curClr = ~curClr;
        applyStimulus(mkWord(1'b1, 8'h63));
        tick();
        checkOutput("ovf cleared", 32'(bus.overflow), 32'd0);

        $display("[TB] reset during pulse");
        sendWrite(1'b1, 8'h71);
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 2) sendWrite(1'b1, 8'h72);
            if (k == 4) sendWrite(1'b1, 8'h73);
        end
        checkOutput("midrst en before", 32'(bus.lcd_en), 32'd1);
        checkOutput("midrst ovf before", 32'(bus.overflow), 32'd1);
        reset_n = 1'b0;
        curToggle = 1'b0;
        applyStimulus(mkWord(1'b0, 8'h00));
        tick();
        checkOutput("midrst en", 32'(bus.lcd_en), 32'd0);
        checkOutput("midrst ovf", 32'(bus.overflow), 32'd0);
        checkOutput("midrst busy", 32'(bus.busy), 32'd0);
        checkOutput("midrst data", 32'(bus.lcd_data), 32'd0);
        tick();
        reset_n = 1'b1;
`ifdef LCD_CTRL_INIT_EN
        checkInitSequence("reinit");
`else
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput("midrst idle busy", 32'(bus.busy), 32'd0);
            checkOutput("midrst idle en", 32'(bus.lcd_en), 32'd0);
        end

        $display("[TB] toggle high at reset release");
        reset_n = 1'b0;
        curToggle = 1'b1;
        applyStimulus(mkWord(1'b1, 8'h5A));
        tick();
        tick();
        reset_n = 1'b1;
        checkWrite("relreq", 1'b1, 8'h5A, TC);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
